mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset is asynchronous, active-low.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports ex_valid in 1; sum_out_in in 32 (PC+4); result_in in 32 (ALU result/address); imm_in in 32; rd_in in 5; we_in in 1; controlRF_in in 2; Type_dm_in in 3 (funct3); data2_in in 32 (store data); store_in in 1. All are EX/MEM register outputs.
REQ-004 SHALL have port stall_o  out  1  holds the EX/MEM register and everything upstream.
REQ-005 SHALL have ports mem_req out 1; mem_we out 1; mem_addr out 32; mem_wstrb out 4; mem_wdata out 32; mem_ready in 1; mem_rdata in 32.
REQ-006 SHALL have ports wb_valid out 1; wb_rd out 5; wb_we out 1; wb_data out 32; misalign_o out 1 (registered MEM/WB outputs).

Function
REQ-007 SHALL classify ops: memop = ex_valid & (store_in | controlRF_in==01); store_in has priority over load; other valid ops are pass-through.
REQ-008 SHALL treat Type_dm 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; 011/110/111 SHALL be treated as word.
REQ-009 SHALL flag misalignment when halfword & addr[0]=1, or word & addr[1:0]!=00 (addr = result_in).
REQ-010 SHALL implement FSM IDLE, WAIT.
REQ-011 IDLE: aligned memop -> latch request, go to WAIT; misaligned memop or pass-through -> stay in IDLE, retire next edge.
REQ-012 WAIT: hold mem_req=1 with mem_we/addr/wstrb/wdata stable until mem_ready=1; that edge SHALL retire the op and return to IDLE.
REQ-013 stall_o = memop & aligned & !(state==WAIT & mem_ready) (combinational); inputs are stable while stall_o=1.
REQ-014 Latency: pass-through and misaligned ops 1 cycle; aligned memop 2 cycles + mem_ready wait cycles; throughput 1 op/cycle for pass-through.
REQ-015 mem_addr = {addr[31:2],2'b00}; mem_we = store.
REQ-016 Store strobes: SB wstrb = 0001<<addr[1:0], wdata = byte replicated x4; SH wstrb = 0011 (addr[1]=0) or 1100, wdata = half replicated x2; SW wstrb = 1111, wdata = data2_in. Loads drive wstrb = 0000.
REQ-017 Load format: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; sign- or zero-extend to 32; LW full word.
REQ-018 wb_data by controlRF: 00 result_in, 01 formatted load data, 10 sum_out_in, 11 imm_in; stores SHALL write wb_data = 0.
REQ-019 On retire: wb_valid=1, wb_rd=rd_in, wb_we=we_in, misalign_o=0; misaligned: no bus request, wb_valid=1, wb_we=0, misalign_o=1 for one cycle.
REQ-020 Cycle with no retire: wb_valid=0, wb_we=0, misalign_o=0; wb_rd/wb_data hold.
REQ-021 mem_rdata SHALL be sampled only in the edge where state==WAIT & mem_ready=1.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE and every output to 0 (stall_o follows REQ-013 once out of reset, registered outputs 0).
REQ-023 Reset during WAIT SHALL drop mem_req asynchronously and abandon the op without writeback.
REQ-024 First edge after rst_n rises SHALL behave as IDLE.

Verification
REQ-025 Pass-through: controlRF=10, sum_out_in=0x104, rd=5, we=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x104, stall_o=0.
REQ-026 LB at addr 0x1003, mem_rdata=0x80FF_0000, ready after 2 WAIT cycles -> mem_addr=0x1000, stall_o high 3 cycles, wb_data=0xFFFF_FF80.
REQ-027 SH at addr 0x2002, data2=0x0000_ABCD, ready immediately -> mem_we=1, wstrb=1100, wdata=0xABCD_ABCD, wb_valid=1, wb_we=0.
REQ-028 LW at addr 0x3001 -> no mem_req, wb_valid=1, misalign_o=1, wb_we=0, stall_o=0.
REQ-029 rst_n=0 in WAIT of LW -> mem_req=0 same cycle, no wb_valid; after release, a new LHU at 0x10 with rdata=0x1234_8000 -> wb_data=0x0000_8000.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage: classifies EX/MEM ops, runs one bus transaction per aligned load/store,
// formats load data and drives the registered MEM/WB outputs.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] sum_out_in,
  input  logic [31:0] result_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rd_in,
  input  logic        we_in,
  input  logic [1:0]  controlRF_in,
  input  logic [2:0]  Type_dm_in,
  input  logic [31:0] data2_in,
  input  logic        store_in,
  output logic        stall_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        misalign_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q;
  logic        mem_req_q, mem_we_q, wb_valid_q, wb_we_q, misalign_q;
  logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q;
  logic [3:0]  mem_wstrb_q;
  logic [4:0]  wb_rd_q;

  logic        memop, misal, sz_byte, sz_half, sz_word;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, load_d, wb_data_d, rdata_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Funct3 low bits give the access size; 011/110/111 fall into the word bucket.
  assign sz_byte = (Type_dm_in[1:0] == 2'b00);
  assign sz_half = (Type_dm_in[1:0] == 2'b01);
  assign sz_word = Type_dm_in[1];
  assign misal   = (sz_half & result_in[0]) | (sz_word & (result_in[1:0] != 2'b00));
  assign memop   = ex_valid & (store_in | (controlRF_in == 2'b01));
  assign stall_o = rst_n & memop & ~misal & ~((state_q == S_WAIT) & mem_ready);

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = data2_in;
    if (store_in) begin
      if (sz_byte) begin
        wstrb_d = 4'b0001 << result_in[1:0];
        wdata_d = {4{data2_in[7:0]}};
      end else if (sz_half) begin
        wstrb_d = result_in[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{data2_in[15:0]}};
      end else begin
        wstrb_d = 4'b1111;
      end
    end
  end

  assign rdata_shift = mem_rdata >> {result_in[1:0], 3'b000};
  assign ld_byte     = rdata_shift[7:0];
  assign ld_half     = result_in[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_d = mem_rdata;
    if (sz_byte)      load_d = {{24{~Type_dm_in[2] & ld_byte[7]}}, ld_byte};
    else if (sz_half) load_d = {{16{~Type_dm_in[2] & ld_half[15]}}, ld_half};
  end

  always_comb begin
    wb_data_d = 32'd0;
    if (!store_in) begin
      case (controlRF_in)
        2'b00:   wb_data_d = result_in;
        2'b01:   wb_data_d = load_d;
        2'b10:   wb_data_d = sum_out_in;
        default: wb_data_d = imm_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wstrb_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
      wb_data_q   <= 32'd0;
      misalign_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (memop && misal) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_in;
            wb_data_q  <= 32'd0;
            misalign_q <= 1'b1;
          end else if (memop) begin
            state_q     <= S_WAIT;
            mem_req_q   <= 1'b1;
            mem_we_q    <= store_in;
            mem_addr_q  <= {result_in[31:2], 2'b00};
            mem_wstrb_q <= wstrb_d;
            mem_wdata_q <= wdata_d;
          end else if (ex_valid) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_in;
            wb_we_q    <= we_in;
            wb_data_q  <= wb_data_d;
          end
        end
        S_WAIT: begin
          // mem_rdata only reaches wb_data on the completing edge.
          if (mem_ready) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_in;
            wb_we_q    <= we_in;
            wb_data_q  <= wb_data_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_we      = wb_we_q;
  assign wb_data    = wb_data_q;
  assign misalign_o = misalign_q;

endmodule
